spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_tx_ser.sv | 67 ++++++
 rtl/spi_slave.sv | 122 ++++++++++++
 tb/tb_spi_slave.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, frame widths and command codes for the SPI slave
package spi_pkg;

  localparam int SPI_FRAME_W = 10;
  localparam int SPI_DATA_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_ser.sv
// rtl/spi_tx_ser.sv - captures one read-data word and shifts it out MSB first on MISO
module spi_tx_ser #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_miso,
  output logic              o_done
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  logic              r_armed;
  logic              r_busy;
  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_miso;
  logic              r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_miso  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_abort) begin
      r_armed <= 1'b0;
      r_busy  <= 1'b0;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_miso  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        if (r_cnt == '0) begin
          r_busy <= 1'b0;
          r_miso <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_miso <= r_sh[DATA_W-1];
          r_sh   <= {r_sh[DATA_W-2:0], 1'b0};
          r_cnt  <= r_cnt - CNT_W'(1);
        end
      // Only the first valid cycle after arming is taken; later ones find r_armed clear.
      end else if ((i_start || r_armed) && i_tx_valid) begin
        r_armed <= 1'b0;
        r_busy  <= 1'b1;
        r_miso  <= i_tx_data[DATA_W-1];
        r_sh    <= {i_tx_data[DATA_W-2:0], 1'b0};
        r_cnt   <= CNT_W'(DATA_W-1);
      end else if (i_start) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_miso = r_miso;
  assign o_done = r_done;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave frame receiver with read-data return; SPI_SLAVE_FRAME_ERR_EN enables aborted-frame pulse
module spi_slave
  import spi_pkg::*;
#(
  parameter int FRAME_W = SPI_FRAME_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               MOSI,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               MISO,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FRAME_W);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-2:0] r_shift;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_rd_addr_seen;
  logic               r_ser_start;
  logic               w_ser_done;
  logic               w_miso;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_ser_start    <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_ser_start <= 1'b0;
      if (SS_n && r_state != IDLE) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_shift <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!SS_n) begin
              r_state <= CHK_CMD;
              r_cnt   <= '0;
            end
          end
          CHK_CMD: begin
            r_shift <= {{(FRAME_W-2){1'b0}}, MOSI};
            r_cnt   <= CNT_W'(1);
            if (!MOSI)
              r_state <= WRITE;
            else if (!r_rd_addr_seen)
              r_state <= READ_ADD;
            else
              r_state <= READ_DATA;
          end
          default: begin
            // Once the frame is full, further MOSI bits are dropped until SS_n rises.
            if (r_cnt < FULL) begin
              r_shift <= {r_shift[FRAME_W-3:0], MOSI};
              r_cnt   <= r_cnt + CNT_W'(1);
              if (r_cnt == LAST_BIT) begin
                r_rx_data  <= {r_shift, MOSI};
                r_rx_valid <= 1'b1;
                if (r_state == READ_ADD)
                  r_rd_addr_seen <= 1'b1;
                if (r_state == READ_DATA)
                  r_ser_start <= 1'b1;
              end
            end
          end
        endcase
      end
      if (w_ser_done)
        r_rd_addr_seen <= 1'b0;
    end
  end

  spi_tx_ser #(
    .DATA_W (DATA_W)
  ) u_tx_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (r_ser_start),
    .i_abort    (SS_n),
    .i_tx_data  (tx_data),
    .i_tx_valid (tx_valid),
    .o_miso     (w_miso),
    .o_done     (w_ser_done)
  );

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_frame_err <= 1'b0;
    else
      r_frame_err <= SS_n && (r_state != IDLE) && (r_cnt != '0) && (r_cnt < FULL);
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign MISO     = w_miso;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave with frame vector table and rx_data scoreboard
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       MISO;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  logic prev_rxv = 1'b0;

`ifdef SPI_SLAVE_FRAME_ERR_EN
  localparam logic EXP_FERR = 1'b1;
`else
  localparam logic EXP_FERR = 1'b0;
`endif

  typedef struct {
    logic [9:0] frame;
    logic [7:0] tx;
    state_t     exp_state;
    logic       exp_seen;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  spi_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .MISO      (MISO),
    .frame_err (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_valid pulse pops one expected frame.
  always @(negedge clk) begin
    if (rx_valid) begin
      chk("rx_valid_one_cycle", {31'b0, prev_rxv}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected actual rx_data=%0h required no rx_valid", rx_data);
      end else begin
        chk("rx_data", {22'b0, rx_data}, {22'b0, exp_q.pop_front()});
      end
    end
    prev_rxv = rx_valid;
  end

  task automatic send_bits(input logic [9:0] f, input int nbits);
    SS_n = 1'b0;
    @(negedge clk);
    for (int i = 9; i > 9 - nbits; i--) begin
      MOSI = f[i];
      @(negedge clk);
    end
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    chk("frame_err_after_full", {31'b0, frame_err}, 32'd0);
    chk("state_idle_after_ss", {29'b0, dut.r_state}, {29'b0, IDLE});
    @(negedge clk);
  endtask

  task automatic check_miso(input logic [7:0] b);
    logic e;
    tx_data  = b;
    tx_valid = 1'b1;
    chk("miso_before_capture", {31'b0, MISO}, 32'd0);
    for (int k = 1; k <= 11; k++) begin
      MOSI = 1'($urandom);
      @(negedge clk);
      if (k == 5) tx_valid = 1'b0;
      e = (k >= 1 && k <= 8) ? b[8-k] : 1'b0;
      checks++;
      if (MISO !== e) begin
        failures++;
        $display("FAIL miso_bit k=%0d actual=%0b required=%0b", k, MISO, e);
      end
    end
  endtask

  initial begin
    vecs[0] = '{10'h0A5, 8'h00, WRITE,     1'b0};
    vecs[1] = '{10'h13C, 8'h00, WRITE,     1'b0};
    vecs[2] = '{10'h20F, 8'h00, READ_ADD,  1'b1};
    vecs[3] = '{10'h300, 8'hC3, READ_DATA, 1'b0};
    vecs[4] = '{10'h2AA, 8'h00, READ_ADD,  1'b1};
    vecs[5] = '{10'h255, 8'h5A, READ_DATA, 1'b0};
    vecs[6] = '{10'h1FF, 8'h00, WRITE,     1'b0};
    vecs[7] = '{10'h3FF, 8'h00, READ_ADD,  1'b1};

    repeat (2) @(negedge clk);
    chk("reset_rx_data", {22'b0, rx_data}, 32'd0);
    chk("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("reset_miso", {31'b0, MISO}, 32'd0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
    chk("reset_state", {29'b0, dut.r_state}, {29'b0, IDLE});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(vecs[v].frame);
      send_bits(vecs[v].frame, 10);
      chk("frame_state", {29'b0, dut.r_state}, {29'b0, vecs[v].exp_state});
      if (vecs[v].exp_state == READ_DATA) begin
        check_miso(vecs[v].tx);
      end else begin
        for (int k = 0; k < 4; k++) begin
          chk("miso_idle", {31'b0, MISO}, 32'd0);
          MOSI = 1'($urandom);
          @(negedge clk);
        end
      end
      chk("rd_addr_seen", {31'b0, dut.r_rd_addr_seen}, {31'b0, vecs[v].exp_seen});
      end_frame();
    end

    // Partial WRITE frame: 5 bits then SS_n rises.
    send_bits(10'h0F0, 5);
    SS_n = 1'b1;
    @(negedge clk);
    chk("abort_state_idle", {29'b0, dut.r_state}, {29'b0, IDLE});
    chk("abort_frame_err", {31'b0, frame_err}, {31'b0, EXP_FERR});
    @(negedge clk);
    chk("abort_frame_err_pulse", {31'b0, frame_err}, 32'd0);
    chk("abort_seen_kept", {31'b0, dut.r_rd_addr_seen}, 32'd1);

    // SS_n rises during the MISO shift.
    exp_q.push_back(10'h301);
    send_bits(10'h301, 10);
    chk("midmiso_state", {29'b0, dut.r_state}, {29'b0, READ_DATA});
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    chk("midmiso_b7", {31'b0, MISO}, 32'd1);
    @(negedge clk);
    chk("midmiso_b6", {31'b0, MISO}, 32'd0);
    @(negedge clk);
    chk("midmiso_b5", {31'b0, MISO}, 32'd1);
    SS_n = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk("midmiso_abort_miso", {31'b0, MISO}, 32'd0);
    chk("midmiso_abort_idle", {29'b0, dut.r_state}, {29'b0, IDLE});
    chk("midmiso_no_frame_err", {31'b0, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    chk("midmiso_miso_stays0", {31'b0, MISO}, 32'd0);
    chk("midmiso_seen_kept", {31'b0, dut.r_rd_addr_seen}, 32'd1);

    exp_q.push_back(10'h3C0);
    send_bits(10'h3C0, 10);
    chk("reread_state", {29'b0, dut.r_state}, {29'b0, READ_DATA});
    check_miso(8'h96);
    chk("reread_seen_cleared", {31'b0, dut.r_rd_addr_seen}, 32'd0);
    end_frame();

    // Reset in the middle of a frame.
    send_bits(10'h2F0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rx_data", {22'b0, rx_data}, 32'd0);
    chk("rst_mid_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_mid_miso", {31'b0, MISO}, 32'd0);
    chk("rst_mid_frame_err", {31'b0, frame_err}, 32'd0);
    chk("rst_mid_state", {29'b0, dut.r_state}, {29'b0, IDLE});
    chk("rst_mid_seen", {31'b0, dut.r_rd_addr_seen}, 32'd0);
    @(negedge clk);
    SS_n  = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {29'b0, dut.r_state}, {29'b0, IDLE});

    exp_q.push_back(10'h0A5);
    send_bits(10'h0A5, 10);
    chk("post_rst_state", {29'b0, dut.r_state}, {29'b0, WRITE});
    @(negedge clk);
    end_frame();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
